// File: rtl/envelope_generator.sv
// Per-channel amplitude envelope: walks a {amp, hold} step table in the shared
// sound ROM, holding each step for its hold count of ticks until a terminator.
module envelope_generator #(
    parameter int ADDR_WIDTH = 8,
    parameter int AMP_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_envelope_base,
    output logic                  o_rom_rd,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [7:0]            i_rom_data,
    output logic [AMP_WIDTH-1:0]  o_amplitude,
    output logic                  o_done,
    output logic                  o_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ADVANCE,
        FETCH,
        WAIT_ROM,
        VALID
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            hold_q;
    logic [AMP_WIDTH-1:0]  amp_q;
    logic                  done_q;
    logic                  valid_q;
    logic                  rd_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            amp_q   <= '0;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_enable) begin
                        if (i_load) begin
                            ptr_q   <= i_envelope_base;
                            addr_q  <= i_envelope_base;
                            rd_q    <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            state_q <= ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    // A zero hold while not done cannot arise; treat it like sustain.
                    if (done_q || hold_q == 4'd0) begin
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end else if (hold_q > 4'd1) begin
                        hold_q  <= hold_q - 4'd1;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                        addr_q  <= ptr_q + 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= WAIT_ROM;
                end
                WAIT_ROM: begin
                    amp_q   <= i_rom_data[7:4];
                    hold_q  <= i_rom_data[3:0];
                    done_q  <= (i_rom_data[3:0] == 4'd0);
                    valid_q <= 1'b1;
                    state_q <= VALID;
                end
                VALID: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_rom_rd    = rd_q;
    assign o_rom_addr  = addr_q;
    assign o_amplitude = amp_q;
    assign o_done      = done_q;
    assign o_valid     = valid_q;

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- Per-channel amplitude envelope stage, driven by the channel controller's envelope enable/load strobes.
- Returns a one-cycle valid pulse to the controller when each operation completes.
- On load it walks a step table in the shared sound ROM: the controller sets its ROM source to "envelope" while this block drives the ROM address.
- On each tick it advances a hold counter and fetches the next step when the hold expires; the current amplitude feeds the channel mixer.

Parameters:
- ADDR_WIDTH, 8, shared ROM address width; the step pointer wraps modulo 2^ADDR_WIDTH.
- AMP_WIDTH, 4, amplitude width; the ROM byte is {amp[7:4], hold[3:0]}, so this parameter is fixed at 4 for 8-bit ROM data.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  one-cycle operation strobe (advance, or load when i_load is also high)
- i_load  in  1  qualifies i_enable: restart the envelope from i_envelope_base
- i_envelope_base  in  ADDR_WIDTH  ROM address of the first step; sampled on load
- o_rom_rd  out  1  ROM read strobe, one cycle
- o_rom_addr  out  ADDR_WIDTH  ROM address; valid while o_rom_rd is high
- i_rom_data  in  8  ROM read data; valid the cycle after o_rom_rd (fixed latency of 1)
- o_amplitude  out  AMP_WIDTH  current envelope amplitude
- o_done  out  1  envelope has reached its terminator and is sustaining
- o_valid  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state IDLE; o_amplitude 0; o_done 1
  - o_valid 0; o_rom_rd 0; o_rom_addr 0
  - internal pointer 0; hold_cnt 0
- Reset asserted mid-operation aborts it; no o_valid pulse is produced for the aborted operation.
- States: IDLE, ADVANCE, FETCH, WAIT_ROM, VALID.
- IDLE:
  - i_enable & i_load: ptr <= i_envelope_base; o_done <= 0; go to FETCH.
  - i_enable & !i_load: go to ADVANCE.
  - i_load without i_enable is ignored.
- ADVANCE (one cycle):
  - o_done=1: no change; go to VALID.
  - hold_cnt > 1: hold_cnt <= hold_cnt-1; go to VALID.
  - hold_cnt == 1: ptr <= ptr+1 (wraps); go to FETCH.
- FETCH: o_rom_rd=1, o_rom_addr=ptr; go to WAIT_ROM.
- WAIT_ROM: capture i_rom_data as amp=[7:4], hold=[3:0].
  - hold != 0: o_amplitude <= amp; hold_cnt <= hold.
  - hold == 0 (terminator): o_amplitude <= amp; o_done <= 1; hold_cnt <= 0.
  - In both cases go to VALID.
- VALID: o_valid=1 for exactly one cycle; go to IDLE. o_amplitude and o_done are already updated in this cycle.
- Hold semantics: a step's amplitude is presented for HOLD ticks, counting the tick on which it was fetched.
- Latency, counted from the cycle i_enable is sampled (cycle 0):
  - load: o_rom_rd in cycle 1, o_valid in cycle 3
  - plain advance, no fetch: o_valid in cycle 2
  - advance with fetch: o_rom_rd in cycle 2, o_valid in cycle 4
- i_enable outside IDLE is ignored; the controller never issues one while busy.
- A load while sustaining (o_done=1) or mid-hold restarts from the new base; the previous amplitude holds until WAIT_ROM.
- Enable before any load: o_done=1, amplitude 0; o_valid still pulses in cycle 2.
- o_rom_addr holds its last value when o_rom_rd is low.
- o_rom_rd is never asserted outside FETCH.

Test Plan:
- Reset: assert i_rst asynchronously between clock edges. Required: o_amplitude=0, o_done=1, o_valid=0, o_rom_rd=0 immediately, and state IDLE.
- Load: ROM[0x10]=0xF2, ROM[0x11]=0x81, ROM[0x12]=0x40; pulse enable+load with base=0x10. Required: rd with addr 0x10 in cycle 1; valid in cycle 3 with amp=15, done=0.
- Hold, expiry and terminator (continuing the load scenario):
  - enable: valid in cycle 2, amp=15, no rd
  - enable: rd with addr 0x11 in cycle 2; valid in cycle 4, amp=8
  - enable: rd with addr 0x12; valid with amp=4, done=1
- Sustain: after the terminator, 3 further enables. Required: each gives valid in cycle 2, amp=4, done=1, and no rd.
- Wrap: ROM[0xFF]=0x31, ROM[0x00]=0x70; load base=0xFF, then enable. Required: second fetch addr=0x00; result amp=7, done=1.
- Abort and restart: reset during WAIT_ROM, then enable without load. Required:
  - no valid pulse from the aborted operation
  - valid in cycle 2 with amp=0, done=1
  - a reload while sustaining restarts at the new base
